// File: rtl/capture_pkg.sv
`default_nettype none
// ============================================================================
// Package     : capture_pkg
// Description : Shared types and constants for the capture read-back path.
// Revision    : 1.0 - initial release
// ============================================================================
package capture_pkg;

    typedef enum logic [1:0] {
        RB_IDLE  = 2'd0,
        RB_REQ   = 2'd1,
        RB_WAIT  = 2'd2,
        RB_DRAIN = 2'd3
    } rb_state_t;

    localparam int RD_LEN_W   = 5;
    localparam int ADDR_SHIFT = 2;
    localparam int IDX_W      = 32 - ADDR_SHIFT;

endpackage : capture_pkg
`default_nettype wire

// File: rtl/rb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rb_fifo
// Description : Synchronous first-word-fall-through FIFO with flush and
//               free-entry count for read-back credit checking.
// Revision    : 1.0 - initial release
// ============================================================================
module rb_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            core_clk,
    input  logic                            core_rst_n,
    input  logic                            flush,
    input  logic                            wr_en,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            rd_en,
    output logic [DATA_W-1:0]               head,
    output logic                            empty,
    output logic                            full,
    output logic [$clog2(FIFO_DEPTH):0]     free
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_wr;
    logic              w_rd;

    assign w_wr  = wr_en & ~full;
    assign w_rd  = rd_en & ~empty;
    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(FIFO_DEPTH));
    assign free  = CW'(FIFO_DEPTH) - r_count;
    assign head  = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge core_clk) begin
        if (!core_rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; the head is masked to zero while empty.
    always_ff @(posedge core_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule : rb_fifo
`default_nettype wire

// File: rtl/capture_readback.sv
`default_nettype none
// ============================================================================
// Module      : capture_readback
// Description : Reads the circular capture buffer out of sample memory in
//               time order and streams it to the host. Optional abort input
//               enabled with `define READBACK_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_readback
    import capture_pkg::*;
#(
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 16
) (
    input  logic                core_clk,
    input  logic                core_rst_n,
    input  logic                rb_start,
    input  logic [31:0]         sd_saddr,
    input  logic [31:0]         sample_depth,
`ifdef READBACK_ABORT_EN
    input  logic                rb_abort,
`endif
    output logic                rd_req,
    output logic [31:0]         rd_addr,
    output logic [RD_LEN_W-1:0] rd_len,
    input  logic                rd_ack,
    input  logic                rd_valid,
    input  logic [DATA_W-1:0]   rd_data,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    input  logic                out_ready,
    output logic                rb_busy,
    output logic                rb_done
);

    localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;

    rb_state_t           r_state;
    rb_state_t           w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [31:0]         r_remain;
    logic [31:0]         r_sent;
    logic [31:0]         r_depth;
    logic [RD_LEN_W-1:0] r_beats;
    logic                r_done;
    logic                r_abort;

    logic                w_abort_in;
    logic [31:0]         w_to_wrap;
    logic [31:0]         w_len32;
    logic [RD_LEN_W-1:0] w_len;
    logic [IDX_W:0]      w_idx_sum;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                w_credit_ok;
    logic [FREE_W-1:0]   w_free;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_load;
    logic                w_ack;
    logic                w_beat;
    logic                w_fifo_wr;
    logic                w_flush;
    logic                w_done_set;
    logic                w_abort_set;
    logic                w_req;
    logic                w_unused_bits;

`ifdef READBACK_ABORT_EN
    assign w_abort_in = rb_abort;
`else
    assign w_abort_in = 1'b0;
`endif

    // Burst length: limited by burst size, samples left, and the wrap point.
    always_comb begin
        w_to_wrap = r_depth - {{ADDR_SHIFT{1'b0}}, r_idx};
        w_len32   = 32'(BURST_LEN);
        if (r_remain < w_len32)  w_len32 = r_remain;
        if (w_to_wrap < w_len32) w_len32 = w_to_wrap;
    end

    assign w_len       = w_len32[RD_LEN_W-1:0];
    assign w_credit_ok = (32'(w_free) >= w_len32);
    assign w_idx_sum   = {1'b0, r_idx} + (IDX_W+1)'(w_len);
    assign w_idx_nxt   = ({1'b0, w_idx_sum} == r_depth) ? '0 : w_idx_sum[IDX_W-1:0];
    assign w_pop       = out_valid & out_ready;
    assign out_valid   = ~w_empty;
    assign rb_busy     = (r_state != RB_IDLE);
    assign rb_done     = r_done;

    assign w_unused_bits = ^{sd_saddr[ADDR_SHIFT-1:0], w_len32[31:RD_LEN_W], w_full};

    always_ff @(posedge core_clk) begin
        if (!core_rst_n) r_state <= RB_IDLE;
        else             r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        rd_req      = 1'b0;
        rd_addr     = '0;
        rd_len      = '0;
        w_load      = 1'b0;
        w_ack       = 1'b0;
        w_beat      = 1'b0;
        w_fifo_wr   = 1'b0;
        w_flush     = 1'b0;
        w_done_set  = 1'b0;
        w_abort_set = 1'b0;
        case (r_state)
            RB_IDLE: begin
                if (rb_start) begin
                    if (sample_depth != 32'd0) begin
                        w_load      = 1'b1;
                        w_state_nxt = RB_REQ;
                    end else begin
                        w_done_set  = 1'b1;
                    end
                end
            end
            RB_REQ: begin
                w_req  = w_credit_ok;
                rd_req = w_req;
                if (w_req) begin
                    rd_addr = {r_idx, {ADDR_SHIFT{1'b0}}};
                    rd_len  = w_len;
                end
                // An accepted request must still have its beats consumed.
                if (w_req && rd_ack) begin
                    w_ack       = 1'b1;
                    w_state_nxt = RB_WAIT;
                    if (w_abort_in) begin
                        w_flush     = 1'b1;
                        w_abort_set = 1'b1;
                    end
                end else if (w_abort_in) begin
                    w_flush     = 1'b1;
                    w_done_set  = 1'b1;
                    w_state_nxt = RB_IDLE;
                end
            end
            RB_WAIT: begin
                if (w_abort_in) begin
                    w_flush     = 1'b1;
                    w_abort_set = 1'b1;
                end
                if (rd_valid) begin
                    w_beat    = 1'b1;
                    w_fifo_wr = ~(w_abort_in | r_abort);
                    if (r_beats == RD_LEN_W'(1)) begin
                        if (w_abort_in || r_abort) begin
                            w_done_set  = 1'b1;
                            w_state_nxt = RB_IDLE;
                        end else if (r_remain != 32'd0) begin
                            w_state_nxt = RB_REQ;
                        end else begin
                            w_state_nxt = RB_DRAIN;
                        end
                    end
                end
            end
            RB_DRAIN: begin
                if (w_abort_in) begin
                    w_flush     = 1'b1;
                    w_done_set  = 1'b1;
                    w_state_nxt = RB_IDLE;
                end else if (r_sent == r_depth) begin
                    w_done_set  = 1'b1;
                    w_state_nxt = RB_IDLE;
                end
            end
            default: w_state_nxt = RB_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            r_idx    <= '0;
            r_remain <= '0;
            r_sent   <= '0;
            r_depth  <= '0;
            r_beats  <= '0;
            r_done   <= 1'b0;
            r_abort  <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (w_pop)  r_sent  <= r_sent + 32'd1;
            if (w_beat) r_beats <= r_beats - RD_LEN_W'(1);
            if (w_load) begin
                r_idx    <= sd_saddr[31:ADDR_SHIFT];
                r_remain <= sample_depth;
                r_depth  <= sample_depth;
                r_sent   <= '0;
            end
            if (w_ack) begin
                r_beats  <= w_len;
                r_remain <= r_remain - w_len32;
                r_idx    <= w_idx_nxt;
            end
            if (w_abort_set)                r_abort <= 1'b1;
            else if (w_state_nxt == RB_IDLE) r_abort <= 1'b0;
        end
    end

    rb_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk   (core_clk),
        .core_rst_n (core_rst_n),
        .flush      (w_flush),
        .wr_en      (w_fifo_wr),
        .wr_data    (rd_data),
        .rd_en      (w_pop),
        .head       (out_data),
        .empty      (w_empty),
        .full       (w_full),
        .free       (w_free)
    );

endmodule : capture_readback
`default_nettype wire
